gray_frame_sequencer: RTL and testbench

GRAY_FRAME_SEQUENCER -- requirements
Module: gray_frame_sequencer

---
 rtl/gray_seq_pkg.sv | 25 ++
 rtl/gray_frame_sequencer_if.sv | 17 +
 rtl/gray_pixel_stage.sv | 25 ++
 rtl/gray_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_gray_frame_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the RGB-to-gray frame sequencer.
package gray_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned W_R        = 2;
  localparam int unsigned W_G        = 5;
  localparam int unsigned W_B        = 1;
  localparam int unsigned GRAY_SHIFT = 3;
  localparam int unsigned SUM_W      = 11;

  // Smallest width able to index n items (at least 1).
  function automatic int unsigned addr_width(input int unsigned n);
    addr_width = 1;
    for (int i = 1; i < 32; i++)
      if ((64'd1 << i) < 64'(n)) addr_width = i + 1;
  endfunction

endpackage

// File: rtl/gray_frame_sequencer_if.sv
// Frame-memory read port and gray-memory write port of the sequencer.
interface gray_frame_sequencer_if #(parameter int AW = 22);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_red;
  logic [7:0]    rd_green;
  logic [7:0]    rd_blue;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data,
                  input  rd_red, rd_green, rd_blue, wr_ready);
  modport slave  (input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
                  output rd_red, rd_green, rd_blue, wr_ready);
endinterface

// File: rtl/gray_pixel_stage.sv
// Weighted RGB-to-gray conversion, result registered on ld_i.
module gray_pixel_stage
  import gray_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_i,
  input  rgb_t       rgb_i,
  output logic [7:0] gray_o
);

  logic [SUM_W-1:0] sum;
  logic [7:0]       gray_q;

  // Max sum is 2040, so the shifted result always fits in 8 bits.
  assign sum = SUM_W'(W_R * rgb_i.r + W_G * rgb_i.g + W_B * rgb_i.b);

  always_ff @(posedge clk) begin
    if (!rst_n)    gray_q <= '0;
    else if (ld_i) gray_q <= 8'(sum >> GRAY_SHIFT);
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/gray_frame_sequencer.sv
// Reads an RGB frame pixel by pixel and writes the gray frame with a
// 2-entry skid buffer behind the output register to absorb backpressure.
module gray_frame_sequencer
  import gray_seq_pkg::*;
#(
  parameter int ROW = 1153,
  parameter int COL = 2048,
  parameter int AW  = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  gray_frame_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done
);

  localparam logic [AW-1:0] LAST = AW'(ROW * COL - 1);

  state_e               state_q;
  logic                 rd_en_q, ret_vld_q, wr_en_q, busy_q, done_q;
  logic [AW-1:0]        rd_addr_q, ret_addr_q, wr_addr_q;
  rgb_t [1:0]           skid_rgb_q, skid_rgb_d;
  logic [1:0][AW-1:0]   skid_addr_q, skid_addr_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;

  rgb_t          ret_rgb, stage_rgb;
  logic [AW-1:0] head_addr_d;
  logic          xfer, head_free, pop, push, head_ld, issue_ok;

  assign ret_rgb   = {bus.rd_red, bus.rd_green, bus.rd_blue};
  assign xfer      = wr_en_q & bus.wr_ready;
  assign head_free = ~wr_en_q | xfer;
  assign pop       = head_free & (skid_cnt_q != 2'd0);
  assign push      = ret_vld_q & ((skid_cnt_q != 2'd0) | ~head_free);
  assign head_ld   = head_free & ((skid_cnt_q != 2'd0) | ret_vld_q);
  assign stage_rgb   = pop ? skid_rgb_q[0]  : ret_rgb;
  assign head_addr_d = pop ? skid_addr_q[0] : ret_addr_q;

  always_comb begin
    skid_rgb_d  = skid_rgb_q;
    skid_addr_d = skid_addr_q;
    skid_cnt_d  = skid_cnt_q;
    if (pop) begin
      skid_rgb_d[0]  = skid_rgb_q[1];
      skid_addr_d[0] = skid_addr_q[1];
      skid_cnt_d     = skid_cnt_q - 2'd1;
    end
    if (push) begin
      skid_rgb_d[skid_cnt_d[0]]  = ret_rgb;
      skid_addr_d[skid_cnt_d[0]] = ret_addr_q;
      skid_cnt_d                 = skid_cnt_d + 2'd1;
    end
  end

  // Worst case assumes no write drains: returning + buffered stays <= 2.
  assign issue_ok = (3'(skid_cnt_d) + 3'(rd_en_q)) <= 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      ret_vld_q   <= 1'b0;
      ret_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      skid_rgb_q  <= '0;
      skid_addr_q <= '0;
      skid_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ret_vld_q   <= rd_en_q;
      ret_addr_q  <= rd_addr_q;
      skid_rgb_q  <= skid_rgb_d;
      skid_addr_q <= skid_addr_d;
      skid_cnt_q  <= skid_cnt_d;
      if (head_ld) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= head_addr_d;
      end else if (xfer) begin
        wr_en_q   <= 1'b0;
      end
      unique case (state_q)
        IDLE, DONE: if (start) begin
          state_q   <= RUN;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
        end
        RUN: if (rd_en_q && rd_addr_q == LAST) begin
          state_q <= DRAIN;
          rd_en_q <= 1'b0;
        end else begin
          rd_en_q <= issue_ok;
          if (rd_en_q) rd_addr_q <= rd_addr_q + AW'(1);
        end
        DRAIN: if (xfer && wr_addr_q == LAST) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  gray_pixel_stage u_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (head_ld),
    .rgb_i  (stage_rgb),
    .gray_o (bus.wr_data)
  );

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Scoreboard bench for gray_frame_sequencer on a 2x3 frame with random data and backpressure.
module tb_gray_frame_sequencer;
  import gray_seq_pkg::*;

  localparam int ROW = 2;
  localparam int COL = 3;
  localparam int N   = ROW * COL;
  localparam int AW  = addr_width(N);

  typedef struct {int addr; int gray;} exp_t;

  logic clk = 1'b0;
  logic rst_n, start, busy, done;

  gray_frame_sequencer_if #(.AW(AW)) bus();

  gray_frame_sequencer #(.ROW(ROW), .COL(COL), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   mr [N], mg [N], mb [N];
  exp_t exp_q [$];
  int   rel = 1000;
  int   bp_mode = 0;
  bit   timed = 0;
  int   rd_next = 0, rd_total = 0, xfer_total = 0, frame_wr = 0;
  bit   prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_data;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // RGB frame memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (bus.rd_en && int'(bus.rd_addr) < N) begin
      bus.rd_red   <= 8'(mr[int'(bus.rd_addr)]);
      bus.rd_green <= 8'(mg[int'(bus.rd_addr)]);
      bus.rd_blue  <= 8'(mb[int'(bus.rd_addr)]);
    end else begin
      bus.rd_red   <= 8'($urandom);
      bus.rd_green <= 8'($urandom);
      bus.rd_blue  <= 8'($urandom);
    end
  end

  // rel = cycle index relative to the edge that accepted start (that cycle after it is 1).
  always @(posedge clk) begin
    if (rst_n && start && !busy) rel = 1;
    else rel = rel + 1;
  end

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = ($urandom_range(0, 2) != 0);
        default: bus.wr_ready = !(rel >= 4 && rel <= 8);
      endcase
    end
  end

  // Monitor: scoreboard pops, read order, hold-under-stall, occupancy, timing.
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    if (!rst_n) begin
      rd_total   = 0;
      xfer_total = 0;
      prev_stall = 0;
    end else begin
      if (rel == 1) begin
        rd_next  = 0;
        frame_wr = 0;
      end
      occ = rd_total - xfer_total - int'(bus.wr_en);
      chk("occupancy_le2", longint'(occ <= 2), 1);
      if (prev_stall) begin
        chk("hold_wr_en", bus.wr_en, 1);
        chk("hold_wr_addr", bus.wr_addr, prev_addr);
        chk("hold_wr_data", bus.wr_data, prev_data);
      end
      if (bus.rd_en) begin
        chk("rd_addr_seq", bus.rd_addr, rd_next);
        rd_next++;
        rd_total++;
      end
      if (bus.wr_en && bus.wr_ready) begin
        if (exp_q.size() == 0) chk("write_with_empty_scoreboard", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e.addr);
          chk("wr_data", bus.wr_data, e.gray);
        end
        xfer_total++;
        frame_wr++;
      end
      prev_stall = bus.wr_en && !bus.wr_ready;
      prev_addr  = bus.wr_addr;
      prev_data  = bus.wr_data;
      if (timed && rel >= 1 && rel <= 10) begin
        chk("timing_rd_en", bus.rd_en, longint'(rel <= 6));
        chk("timing_wr_en", bus.wr_en, longint'(rel >= 3 && rel <= 8));
        chk("timing_done", done, longint'(rel >= 9));
      end
    end
  end

  task automatic load_frame(input bit fixed);
    for (int i = 0; i < N; i++) begin
      mr[i] = $urandom_range(0, 255);
      mg[i] = $urandom_range(0, 255);
      mb[i] = $urandom_range(0, 255);
    end
    if (fixed) begin
      mr[0] = 10;  mg[0] = 20;  mb[0] = 30;
      mr[1] = 255; mg[1] = 255; mb[1] = 255;
      mr[2] = 0;   mg[2] = 0;   mb[2] = 0;
    end
    for (int i = 0; i < N; i++)
      exp_q.push_back('{i, (2 * mr[i] + 5 * mg[i] + mb[i]) / 8});
  endtask

  task automatic run_frame(input int bp, input bit tm, input bit fixed, input bit extra,
                           input bit expect_done);
    bit got;
    if (expect_done) chk("done_before_restart", done, 1);
    load_frame(fixed);
    bp_mode = bp;
    timed   = tm;
    start   = 1'b1;
    step();
    start = 1'b0;
    got   = 0;
    for (int i = 0; i < 300; i++) begin
      start = (extra && rel == 3);
      if (done) begin
        got = 1;
        break;
      end
      step();
    end
    start = 1'b0;
    repeat (2) step();
    timed = 0;
    chk("frame_done", got, 1);
    chk("frame_write_count", frame_wr, N);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outputs", {bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr,
                           bus.wr_data, busy, done}, 0);
    end

    run_frame(0, 1, 1, 0, 0);
    run_frame(2, 0, 0, 0, 1);
    run_frame(0, 0, 0, 1, 1);

    // Reset in cycle 4 of a frame.
    load_frame(0);
    bp_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && rel < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    chk("reset_outputs", {bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr,
                          bus.wr_data, busy, done}, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_reset_no_write", bus.wr_en, 0);
    end

    run_frame(0, 0, 1, 0, 0);
    for (int f = 0; f < 6; f++) run_frame(1, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
